// File: rtl/core_if_stage.sv
// -----------------------------------------------------------------------------
// core_if_stage
// Instruction-fetch stage. Holds the fetch PC, issues word requests on a
// req/gnt/rvalid instruction-memory port, buffers returned words together with
// their PC, and hands them to decode under a valid/ready handshake. A redirect
// flushes buffered words and arranges for in-flight responses to be dropped.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   imem_req_o, imem_addr_o   fetch request and word-aligned address
//   imem_gnt_i                request accepted this cycle
//   imem_rvalid_i/rdata_i     in-order response word
//   redirect_i, redirect_pc_i single-cycle redirect and its new fetch PC
//   id_ready_i                decode accepts the presented instruction
//   instr_valid_o, instr_o,   instruction and its PC towards decode
//   pc_o                      (NOP / 0 while not valid)
// -----------------------------------------------------------------------------
module core_if_stage #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            id_ready_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);
    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);

    // Architectural state
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_pending;     // request asserted last cycle without gnt
    logic [XLEN-1:0] r_pend_addr;   // address held while pending
    logic            r_stale;       // pending request belongs to a pre-redirect stream
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   r_fifo_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_tag_wr;
    logic [AW-1:0]   r_tag_rd;

    logic [XLEN-1:0] r_instr_mem [FIFO_DEPTH];
    logic [XLEN-1:0] r_pc_mem    [FIFO_DEPTH];
    logic [XLEN-1:0] r_tag_mem   [FIFO_DEPTH];   // address of each in-flight request

    logic            w_valid;
    logic            w_deq;
    logic [CW:0]     w_occupancy;
    logic            w_credit;
    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_grant;
    logic            w_stale_grant;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_inflight_next;
    logic [CW-1:0]   w_discard_next;
    logic [XLEN-1:0] w_fetch_pc_next;
    logic            w_stale_next;
    logic            w_unused_pc_bits;

    assign w_unused_pc_bits = ^redirect_pc_i[1:0];

    assign w_valid = (r_fifo_count != '0);
    assign w_deq   = w_valid & id_ready_i;

    // A slot being popped this cycle is free before any new response can
    // arrive (rvalid is at least one cycle after gnt), so it counts as credit.
    // This is what allows a grant every cycle with a two-entry buffer.
    assign w_occupancy = {1'b0, r_fifo_count} + {1'b0, r_inflight} - {{CW{1'b0}}, w_deq};
    assign w_credit    = (w_occupancy < DEPTH_W);

    assign w_req         = ~rst_i & (r_pending | w_credit);
    assign w_addr        = r_pending ? r_pend_addr : r_fetch_pc;
    assign w_grant       = w_req & imem_gnt_i;
    assign w_stale_grant = w_grant & r_stale;

    assign w_drop = imem_rvalid_i & (r_discard != '0);
    assign w_push = imem_rvalid_i & ~w_drop & ~redirect_i;
    assign w_pop  = w_deq & ~redirect_i;

    assign w_inflight_next = r_inflight + CW'(w_grant) - CW'(imem_rvalid_i);

    always_comb begin
        w_discard_next  = r_discard + CW'(w_stale_grant) - CW'(w_drop);
        w_fetch_pc_next = r_fetch_pc;
        w_stale_next    = r_stale;
        if (w_grant && !r_stale) begin
            w_fetch_pc_next = r_fetch_pc + XLEN'(4);
        end
        if (w_grant) begin
            w_stale_next = 1'b0;
        end
        if (redirect_i) begin
            // Everything still out in memory after this cycle is now stale.
            w_discard_next  = w_inflight_next;
            w_fetch_pc_next = {redirect_pc_i[XLEN-1:2], 2'b00};
            // An ungranted request must stay stable, so it is issued later
            // as a stale fetch instead of being withdrawn.
            if (w_req && !imem_gnt_i) begin
                w_stale_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc   <= RESET_PC;
            r_pending    <= 1'b0;
            r_pend_addr  <= '0;
            r_stale      <= 1'b0;
            r_inflight   <= '0;
            r_discard    <= '0;
            r_fifo_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tag_wr     <= '0;
            r_tag_rd     <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            r_pending  <= w_req & ~imem_gnt_i;
            if (w_req && !imem_gnt_i) begin
                r_pend_addr <= w_addr;
            end
            r_stale    <= w_stale_next;
            r_inflight <= w_inflight_next;
            r_discard  <= w_discard_next;
            if (w_grant) begin
                r_tag_wr <= r_tag_wr + AW'(1);
            end
            if (imem_rvalid_i) begin
                r_tag_rd <= r_tag_rd + AW'(1);
            end
            if (redirect_i) begin
                r_fifo_count <= '0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
            end else begin
                r_fifo_count <= r_fifo_count + CW'(w_push) - CW'(w_pop);
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and counts.
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_tag_mem[r_tag_wr] <= w_addr;
        end
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_rdata_i;
            r_pc_mem[r_wr_ptr]    <= r_tag_mem[r_tag_rd];
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = w_addr;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? r_instr_mem[r_rd_ptr] : NOP;
    assign pc_o          = w_valid ? r_pc_mem[r_rd_ptr] : '0;

`ifndef SYNTHESIS
    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rvalid_i && (r_inflight == '0)))
        else $error("core_if_stage: rvalid with nothing in flight");

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && !w_pop && (r_fifo_count == CW'(FIFO_DEPTH))))
        else $error("core_if_stage: instruction buffer overflow");
`endif

endmodule

// File: tb/tb_core_if_stage.sv
// -----------------------------------------------------------------------------
// tb_core_if_stage
// Drives core_if_stage with a behavioural instruction memory (random grant and
// latency), random decode stalls and redirects. Every current-stream grant
// pushes the instruction decode must eventually see; a monitor pops and
// compares on each decode handshake.
// Timing inside each low clock phase: +0 reset, +1 inputs, +2 grant decision,
// +3 monitor, +4 directed checks.
// -----------------------------------------------------------------------------
module tb_core_if_stage;
    localparam int          XLEN       = 32;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;

    core_if_stage #(
        .XLEN       (XLEN),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .id_ready_i    (id_ready),
        .instr_valid_o (valid),
        .instr_o       (instr),
        .pc_o          (pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Knobs set by the main sequence on posedges
    int          gnt_mode  = 1;   // 0 never, 1 always, 2 random, 3 after 3 waits
    int          lat_min   = 0;
    int          lat_max   = 0;
    int          ready_pct = 100;
    int          redir_pct = 0;
    logic        redir_req = 1'b0;
    logic [31:0] redir_tgt = '0;
    int          redir_min_inflight = 0;

    // Reference model of the fetch stream
    logic [31:0] model_pc   = RESET_PC;
    logic        stale_pend = 1'b0;
    logic        prev_hold  = 1'b0;
    logic [31:0] prev_addr  = '0;
    int          req_age    = 0;
    int          gnt_count  = 0;
    int          first_gnt_cyc   = -1;
    int          first_valid_cyc = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory, decode and redirect driver plus fetch-stream model
    initial begin : driver
        logic        do_redir;
        logic        g;
        logic [31:0] tgt;
        mem_t        m;
        exp_t        e;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                gnt = 1'b0; rvalid = 1'b0; redirect = 1'b0; id_ready = 1'b0;
                mem_q.delete();
                exp_q.delete();
                model_pc = RESET_PC; stale_pend = 1'b0; prev_hold = 1'b0; req_age = 0;
                continue;
            end
            id_ready = ($urandom_range(99) < ready_pct);
            do_redir = 1'b0;
            tgt      = $urandom;
            if (redir_req) begin
                if (mem_q.size() >= redir_min_inflight) begin
                    do_redir  = 1'b1;
                    tgt       = redir_tgt;
                    redir_req = 1'b0;
                end
            end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
                do_redir = 1'b1;
            end
            redirect    = do_redir;
            redirect_pc = tgt;
            rvalid = 1'b0;
            rdata  = $urandom;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                m = mem_q.pop_front();
                rvalid = 1'b1;
                rdata  = mem_word(m.addr);
            end
            #1;
            if (prev_hold) begin
                check("req_held", 32'(req), 32'd1);
                check("addr_held", addr, prev_addr);
            end
            g = 1'b0;
            if (req) begin
                case (gnt_mode)
                    1:       g = 1'b1;
                    2:       g = 1'($urandom_range(1));
                    3:       g = (req_age >= 3);
                    default: g = 1'b0;
                endcase
            end
            gnt = g;
            if (req && !g) begin
                req_age++;
                prev_hold = 1'b1;
                prev_addr = addr;
            end else begin
                req_age   = 0;
                prev_hold = 1'b0;
            end
            if (req && g) begin
                gnt_count++;
                if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
                m.addr = addr;
                m.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
                mem_q.push_back(m);
                if (stale_pend || do_redir) begin
                    stale_pend = 1'b0;
                end else begin
                    check("fetch_addr", addr, model_pc);
                    e.pc    = model_pc;
                    e.instr = mem_word(model_pc);
                    exp_q.push_back(e);
                    model_pc = model_pc + 32'd4;
                end
            end
            if (do_redir) begin
                exp_q.delete();
                model_pc   = {tgt[31:2], 2'b00};
                stale_pend = req && !g;
            end
        end
    end

    // Decode-side monitor
    initial begin : monitor
        logic redir_d;
        exp_t e;
        redir_d = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                redir_d = 1'b0;
                continue;
            end
            if (redir_d) check("valid_after_redirect", 32'(valid), 32'd0);
            if (!valid) begin
                check("nop_when_idle", instr, NOP);
                check("pc_when_idle", pc, 32'd0);
            end else begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (id_ready && !redirect) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_instr: got pc %08h instr %08h, expected none", pc, instr);
                    end else begin
                        e = exp_q.pop_front();
                        check("pc_o", pc, e.pc);
                        check("instr_o", instr, e.instr);
                        $display("[TB] cyc %0d decode pc=%08h instr=%08h", cyc, pc, instr);
                    end
                end
            end
            redir_d = redirect;
        end
    end

    task automatic fire_redirect(input logic [31:0] t, input int min_inflight);
        redir_tgt          = t;
        redir_min_inflight = min_inflight;
        redir_req          = 1'b1;
        for (int i = 0; i < 40 && redir_req; i++) @(posedge clk);
        if (redir_req) begin
            redir_req = 1'b0;
            check("redirect_fired", 32'd0, 32'd1);
        end
    endtask

    initial begin : main
        int g0;
        int d;
        bit seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        check("rst_req", 32'(req), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc", pc, 32'd0);
        check("rst_addr", addr, RESET_PC);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back fetch with single-cycle memory
        repeat (12) @(posedge clk);
        check("first_valid_latency", 32'(first_valid_cyc - first_gnt_cyc), 32'd2);
        g0 = gnt_count;
        repeat (8) @(posedge clk);
        check("b2b_grants", 32'(gnt_count - g0), 32'd8);

        // Decode stall: buffer fills, requests stop
        ready_pct = 0;
        repeat (6) @(posedge clk);
        g0 = gnt_count;
        repeat (4) @(posedge clk);
        check("stall_grants", 32'(gnt_count - g0), 32'd0);
        @(negedge clk);
        #4;
        check("stall_req", 32'(req), 32'd0);
        check("stall_valid", 32'(valid), 32'd1);
        check("stall_inflight", 32'(mem_q.size()), 32'd0);
        @(posedge clk);
        ready_pct = 100;
        repeat (10) @(posedge clk);

        // Delayed grant: request must hold still
        gnt_mode = 3;
        g0 = gnt_count;
        repeat (20) @(posedge clk);
        d = gnt_count - g0;
        n_tests++;
        if (d < 4 || d > 6) begin
            n_fail++;
            $display("FAIL delayed_grants: got %0d grants, expected 4..6", d);
        end

        // Redirect to 0x103 with two requests in flight
        gnt_mode = 1;
        lat_min  = 3;
        lat_max  = 3;
        repeat (12) @(posedge clk);
        fire_redirect(32'h0000_0103, 2);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            #4;
            if (valid) seen = 1'b1;
        end
        check("redirect_first_pc", seen ? pc : 32'hDEAD_BEEF, 32'h0000_0100);

        // Redirect coinciding with rvalid and pop
        lat_min = 0;
        lat_max = 0;
        repeat (8) @(posedge clk);
        fire_redirect(32'h0000_0200, 1);
        @(negedge clk);
        #4;
        check("redirect_flush_valid", 32'(valid), 32'd0);
        repeat (10) @(posedge clk);

        // Wrap at the top of the address space
        fire_redirect(32'hFFFF_FFFC, 0);
        repeat (12) @(posedge clk);

        // Randomised traffic with a reset in the middle
        gnt_mode  = 2;
        lat_min   = 0;
        lat_max   = 3;
        ready_pct = 70;
        redir_pct = 4;
        repeat (1500) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        check("midrst_req", 32'(req), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_addr", addr, RESET_PC);
        @(negedge clk);
        rst = 1'b0;
        repeat (1500) @(posedge clk);

        // Drain: everything granted for the current stream must arrive
        redir_pct = 0;
        gnt_mode  = 0;
        ready_pct = 100;
        for (int i = 0; i < 60 && (mem_q.size() > 0 || exp_q.size() > 0); i++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("drain_expected", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
